// File: rtl/calc_sequencer_pkg.sv
// Shared encodings for the calculator sequencer: register control codes,
// op codes, ULA selects and FSM states.
package calc_sequencer_pkg;

    // Register control codes, identical to those decoded by the X/Y/Z registers.
    typedef enum logic [2:0] {
        RC_HOLD   = 3'b000,
        RC_LOAD   = 3'b001,
        RC_SHIFTR = 3'b010,
        RC_SHIFTL = 3'b011,
        RC_CLEAR  = 3'b100
    } reg_code_e;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDX = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_CLR = 3'b110,
        OP_STZ = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        SEL_ADD    = 2'b00,
        SEL_SUB    = 2'b01,
        SEL_PASS_X = 2'b10,
        SEL_PASS_Y = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_shift(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/calc_sequencer_seq_decode.sv
// Combinational control-word decode: maps (state, op) to the X/Y/Z register
// codes and the ULA select. Only EXEC issues a non-HOLD word.
module calc_sequencer_seq_decode
    import calc_sequencer_pkg::*;
#(
    parameter int CODE_W = 4,
    parameter int SEL_W  = 2
) (
    input  state_e            state,
    input  op_e               op,
    output logic [CODE_W-1:0] tx,
    output logic [CODE_W-1:0] ty,
    output logic [CODE_W-1:0] tz,
    output logic [SEL_W-1:0]  sel
);

    reg_code_e cx, cy, cz;
    sel_e      cs;

    always_comb begin
        cx = RC_HOLD;
        cy = RC_HOLD;
        cz = RC_HOLD;
        cs = SEL_PASS_X;
        if (state == ST_EXEC) begin
            case (op)
                OP_NOP: ;
                OP_LDX: cx = RC_LOAD;
                OP_ADD: begin cy = RC_LOAD; cs = SEL_ADD; end
                OP_SUB: begin cy = RC_LOAD; cs = SEL_SUB; end
                OP_SHL: cy = RC_SHIFTL;
                OP_SHR: cy = RC_SHIFTR;
                OP_CLR: begin cx = RC_CLEAR; cy = RC_CLEAR; cz = RC_CLEAR; end
                OP_STZ: begin cz = RC_LOAD; cs = SEL_PASS_Y; end
                default: ;
            endcase
        end
    end

    assign tx  = CODE_W'(cx);
    assign ty  = CODE_W'(cy);
    assign tz  = CODE_W'(cz);
    assign sel = SEL_W'(cs);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM (IDLE/EXEC/DONE) sequencing the X/Y/Z registers and ULA.
// Optional macro SEQ_ABORT_EN adds an abort input that returns EXEC/DONE to IDLE.
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int CODE_W = 4,
    parameter int SEL_W  = 2,
    parameter int AMT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [AMT_W-1:0]  amount,
`ifdef SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic [CODE_W-1:0] Tx,
    output logic [CODE_W-1:0] Ty,
    output logic [CODE_W-1:0] Tz,
    output logic [SEL_W-1:0]  selUla,
    output logic              busy,
    output logic              done
);

    state_e           state, state_nx;
    op_e              op_q;
    logic [AMT_W-1:0] amount_q;
    logic [AMT_W-1:0] cnt_q;
    logic             abort_i;
    logic             accept;
    logic             exec_last;

`ifdef SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // abort outranks start while idle, so a simultaneous pair launches nothing
    assign accept    = (state == ST_IDLE) && start && !abort_i;
    assign exec_last = !is_shift(op_q) || (cnt_q == amount_q - AMT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_NOP;
            amount_q <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            op_q     <= op_e'(op);
            amount_q <= amount;
            cnt_q    <= '0;
        end else if (state == ST_EXEC) begin
            cnt_q    <= cnt_q + AMT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    // a zero-length shift has no work, so it skips EXEC
                    if (is_shift(op_e'(op)) && (amount == '0)) state_nx = ST_DONE;
                    else                                      state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (abort_i)        state_nx = ST_IDLE;
                else if (exec_last) state_nx = ST_DONE;
                else                state_nx = ST_EXEC;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    calc_sequencer_seq_decode #(
        .CODE_W(CODE_W),
        .SEL_W (SEL_W)
    ) u_decode (
        .state(state),
        .op   (op_q),
        .tx   (Tx),
        .ty   (Ty),
        .tz   (Tz),
        .sel  (selUla)
    );

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with a small negedge X/Y/Z/ULA datapath
// model driven by the sequencer outputs.
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [1:0] amount;
    logic [3:0] Tx, Ty, Tz;
    logic [1:0] selUla;
    logic       busy, done;
`ifdef SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif

    always #5 clk = ~clk;

    calc_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .amount(amount),
`ifdef SEQ_ABORT_EN
        .abort (abort),
`endif
        .Tx    (Tx),
        .Ty    (Ty),
        .Tz    (Tz),
        .selUla(selUla),
        .busy  (busy),
        .done  (done)
    );

    // Datapath model: registers sample on negedge, as in the real calculator.
    logic [7:0] x_r, y_r, z_r, din, ula;

    always_comb begin
        ula = 8'h00;
        case (selUla)
            2'b00: ula = x_r + y_r;
            2'b01: ula = y_r - x_r;
            2'b10: ula = x_r;
            2'b11: ula = y_r;
            default: ula = 8'h00;
        endcase
    end

    always @(negedge clk) begin
        case (Tx)
            4'b0001: x_r <= din;
            4'b0100: x_r <= 8'h00;
            default: ;
        endcase
        case (Ty)
            4'b0001: y_r <= ula;
            4'b0010: y_r <= y_r >> 1;
            4'b0011: y_r <= y_r << 1;
            4'b0100: y_r <= 8'h00;
            default: ;
        endcase
        case (Tz)
            4'b0001: z_r <= ula;
            4'b0100: z_r <= 8'h00;
            default: ;
        endcase
    end

    wire [15:0] obs = {Tx, Ty, Tz, selUla, busy, done};

    localparam logic [15:0] IDLE_W = {4'h0, 4'h0, 4'h0, 2'b10, 1'b0, 1'b0};
    localparam logic [15:0] DONE_W = {4'h0, 4'h0, 4'h0, 2'b10, 1'b1, 1'b1};

    logic [15:0] sb[$];
    logic [15:0] exp_w;
    int errors = 0;
    int checks = 0;

    function automatic logic [15:0] exec_word(input logic [2:0] o);
        case (o)
            3'b000: return {4'h0, 4'h0, 4'h0, 2'b10, 1'b1, 1'b0};
            3'b001: return {4'h1, 4'h0, 4'h0, 2'b10, 1'b1, 1'b0};
            3'b010: return {4'h0, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0};
            3'b011: return {4'h0, 4'h1, 4'h0, 2'b01, 1'b1, 1'b0};
            3'b100: return {4'h0, 4'h3, 4'h0, 2'b10, 1'b1, 1'b0};
            3'b101: return {4'h0, 4'h2, 4'h0, 2'b10, 1'b1, 1'b0};
            3'b110: return {4'h4, 4'h4, 4'h4, 2'b10, 1'b1, 1'b0};
            default: return {4'h0, 4'h0, 4'h1, 2'b11, 1'b1, 1'b0};
        endcase
    endfunction

    // Drive a start and queue the cycle-by-cycle output words it must produce.
    task automatic launch(input logic [2:0] o, input int amt, input logic [7:0] d);
        int n;
        din    = d;
        op     = o;
        amount = 2'(amt);
        start  = 1'b1;
        n = ((o == 3'b100) || (o == 3'b101)) ? amt : 1;
        for (int i = 0; i < n; i++) sb.push_back(exec_word(o));
        sb.push_back(DONE_W);
        sb.push_back(IDLE_W);
    endtask

    // Setup-only operation: run to completion without checking outputs.
    task automatic run_quiet(input logic [2:0] o, input int amt, input logic [7:0] d);
        int k;
        launch(o, amt, d);
        sb.delete();
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) begin
            errors++;
            $display("FAIL setup_done_timeout: done=%b required 1", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 3'b000; amount = 2'b00; din = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== IDLE_W) begin
                errors++;
                $display("FAIL reset_hold: got %h required %h", obs, IDLE_W);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== IDLE_W) begin
                errors++;
                $display("FAIL reset_idle: got %h required %h", obs, IDLE_W);
            end
        end
    endtask

    task automatic test_add;
        run_quiet(3'b110, 0, 8'h00);
        run_quiet(3'b001, 0, 8'h04);
        run_quiet(3'b010, 0, 8'h00);
        run_quiet(3'b001, 0, 8'h03);
        launch(3'b010, 0, 8'h00);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp_w = sb.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL add_word: got %h required %h", obs, exp_w);
            end
        end
        checks++;
        if (y_r !== 8'd7) begin
            errors++;
            $display("FAIL add_y: Y=%0d required 7", y_r);
        end
        run_quiet(3'b111, 0, 8'h00);
        checks++;
        if (z_r !== 8'd7) begin
            errors++;
            $display("FAIL stz_z: Z=%0d required 7", z_r);
        end
    endtask

    task automatic test_shl;
        run_quiet(3'b110, 0, 8'h00);
        run_quiet(3'b001, 0, 8'h01);
        run_quiet(3'b010, 0, 8'h00);
        launch(3'b100, 3, 8'h00);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            exp_w = sb.pop_front();
            // keep hammering start while busy; none of it may launch
            start = (sb.size() > 0);
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL shl_word: got %h required %h", obs, exp_w);
            end
        end
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== IDLE_W) begin
                errors++;
                $display("FAIL shl_no_requeue: got %h required %h", obs, IDLE_W);
            end
        end
        checks++;
        if (y_r !== 8'd8) begin
            errors++;
            $display("FAIL shl_y: Y=%0d required 8", y_r);
        end
    endtask

    task automatic test_shr_zero;
        launch(3'b101, 0, 8'h00);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp_w = sb.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL shr0_word: got %h required %h", obs, exp_w);
            end
        end
        checks++;
        if (y_r !== 8'd8) begin
            errors++;
            $display("FAIL shr0_y: Y=%0d required 8", y_r);
        end
    endtask

    task automatic test_reset_mid;
        din = 8'h00; op = 3'b100; amount = 2'd3; start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (obs !== exec_word(3'b100)) begin
                errors++;
                $display("FAIL midrst_exec: got %h required %h", obs, exec_word(3'b100));
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== IDLE_W) begin
            errors++;
            $display("FAIL midrst_outputs: got %h required %h", obs, IDLE_W);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (y_r !== 8'd32) begin
            errors++;
            $display("FAIL midrst_y: Y=%0d required 32", y_r);
        end
        @(posedge clk); #1;
        launch(3'b000, 0, 8'h00);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp_w = sb.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL midrst_restart: got %h required %h", obs, exp_w);
            end
        end
    endtask

    task automatic test_back_to_back;
        launch(3'b110, 0, 8'h00);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp_w = sb.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL clr_word: got %h required %h", obs, exp_w);
            end
        end
        checks++;
        if ({x_r, y_r, z_r} !== 24'h0) begin
            errors++;
            $display("FAIL clr_regs: XYZ=%h required 000000", {x_r, y_r, z_r});
        end
        launch(3'b111, 0, 8'h00);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp_w = sb.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL stz_word: got %h required %h", obs, exp_w);
            end
        end
    endtask

`ifdef SEQ_ABORT_EN
    task automatic test_abort;
        run_quiet(3'b001, 0, 8'h08);
        run_quiet(3'b010, 0, 8'h00);
        din = 8'h00; op = 3'b101; amount = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (obs !== exec_word(3'b101)) begin
            errors++;
            $display("FAIL abort_exec: got %h required %h", obs, exec_word(3'b101));
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (obs !== IDLE_W) begin
            errors++;
            $display("FAIL abort_idle: got %h required %h", obs, IDLE_W);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== IDLE_W || y_r !== 8'd4) begin
            errors++;
            $display("FAIL abort_y: out=%h Y=%0d required %h Y=4", obs, y_r, IDLE_W);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_shl();
        test_shr_zero();
        test_reset_mid();
        test_back_to_back();
`ifdef SEQ_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control FSM that sequences the calculator datapath: operand register X, accumulator register Y, result register Z and the ULA.
- Accepts one operation per start pulse.
- Drives per-register control codes (Tx/Ty/Tz) and the ULA function select over one or more cycles, then pulses done.
- Sits between the keypad/front-end decoder and the register/ULA datapath.

Parameters:
- CODE_W, 4, width of each register control code (Tx/Ty/Tz).
- SEL_W, 2, width of ULA function select.
- AMT_W, 2, width of shift-amount field; max shift count is 2^AMT_W-1.

Ports:
- clk input 1 system clock; FSM updates on posedge.
- rst input 1 synchronous, active-high reset.
- start input 1 request strobe; sampled only in IDLE.
- op input 3 operation code; captured with start.
- amount input AMT_W shift count for SHL/SHR; captured with start.
- Tx output CODE_W control code for register X.
- Ty output CODE_W control code for register Y.
- Tz output CODE_W control code for register Z.
- selUla output SEL_W ULA function: 00 ADD, 01 SUB, 10 PASS_X, 11 PASS_Y.
- busy output 1 high from the cycle after start is accepted until the done cycle, inclusive.
- done output 1 one-cycle completion pulse.

Behaviour:
- Register control codes (zero-extended to CODE_W): HOLD=000, LOAD=001, SHIFTR=010, SHIFTL=011, CLEAR=100.
- Registers sample on negedge clk. All outputs are decoded only from registered state (state, op_q, cnt_q), so they are stable across the sampling negedge.
- States: IDLE, EXEC, DONE.
- IDLE: all T*=HOLD, selUla=PASS_X, busy=0, done=0.
  - start=1 latches op_q/amount_q and sets cnt_q=0.
  - Next state is EXEC, except SHL/SHR with amount=0, which go straight to DONE.
- EXEC: busy=1. Control word per op_q; every unlisted T* is HOLD:
  - 000 NOP: nothing asserted.
  - 001 LDX: Tx=LOAD.
  - 010 ADD: Ty=LOAD, selUla=ADD.
  - 011 SUB: Ty=LOAD, selUla=SUB.
  - 100 SHL: Ty=SHIFTL.
  - 101 SHR: Ty=SHIFTR.
  - 110 CLR: Tx=Ty=Tz=CLEAR.
  - 111 STZ: Tz=LOAD, selUla=PASS_Y.
- EXEC duration: 1 cycle for all ops except SHL/SHR, which last exactly amount_q cycles.
  - cnt_q increments each EXEC cycle.
  - Leave to DONE when cnt_q == amount_q-1 (or immediately for single-cycle ops).
- DONE: T*=HOLD, busy=1, done=1 for exactly one cycle; next state IDLE.
- start outside IDLE is ignored; it is not queued. start is re-accepted in the IDLE cycle following DONE.
- Latency: start at cycle n gives EXEC at n+1; done at n+2 for single-cycle ops, n+1+amount for shifts (n+1 when amount=0).
- Reset at any point, including mid-EXEC: state=IDLE, op_q=0, amount_q=0, cnt_q=0, all T*=HOLD, selUla=PASS_X, busy=0, done=0, effective the next posedge.
- Datapath registers are not cleared by rst; use CLR for that.

Optional Feature:
- Macro SEQ_ABORT_EN.
- With it: extra input port abort (1 bit).
  - abort=1 in EXEC or DONE moves the FSM to IDLE at the next posedge, without a done pulse. busy falls the same edge.
  - The current cycle's control word is still issued; shifts already performed stand.
  - abort in IDLE has no effect, and has priority over start in the same cycle.
- Without it: no abort port; every accepted operation runs to completion.

Decomposition:
- Shared include file seq_defs.vh holds:
  - register control codes (HOLD/LOAD/SHIFTR/SHIFTL/CLEAR), identical to those used by the X/Y/Z registers;
  - op codes 000–111;
  - selUla codes;
  - FSM state encodings.
- One natural sub-module, seq_decode: purely combinational mapping of (state, op_q) to {Tx, Ty, Tz, selUla}.
- The top module holds the FSM, cnt_q and the handshake.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 -> T*=0000, selUla=10, busy=0, done=0 on every cycle.
- ADD: start with op=010 -> next cycle Ty=0001, selUla=00, Tx=Tz=0000. Following cycle done=1; busy high for both cycles. With X=3, Y=4 and a real datapath, Y=7 after done.
- SHL amount=3 with Y=0001 -> Ty=0011 for exactly 3 consecutive cycles, then done. Y=1000. start pulses during busy are ignored (no second sequence).
- SHR amount=0 -> done on the cycle after start; Ty never leaves 0000.
- Reset mid-operation: SHL amount=3, assert rst in the 2nd EXEC cycle -> next posedge all outputs are at reset values, no done pulse. A new start is accepted immediately after.
- CLR then STZ back-to-back:
  - CLR: Tx=Ty=Tz=0100 for one cycle, then done.
  - start in the following IDLE with op=111: Tz=0001 and selUla=11 for one cycle.
- With SEQ_ABORT_EN: SHR amount=3, abort in the 1st EXEC cycle -> IDLE next edge, done stays 0, Y is shifted exactly once.
